// File: rtl/seg_display_mux.sv
// seg_display_mux
//   Time-multiplexed 4-digit common-anode seven-segment driver. Once per
//   display frame it snapshots A, B, A+B and A-B into a shadow register, then
//   scans the snapshot onto the display as hex characters. The snapshot keeps
//   the readout from glitching when the inputs change in the middle of a frame.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   A, B         operands (4 bits each)
//   AplusB       sum from the math block
//   AminusB      two's-complement difference from the math block
//   hold         when high, the frame-boundary shadow load is skipped
//   an           digit anodes, active-low, one-hot-low while scanning
//                (an[0]=AminusB, an[1]=AplusB, an[2]=B, an[3]=A)
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   frame        one-cycle pulse after every shadow load
//
// Configuration macro
//   SEG_DP_NEG_EN  when defined, dp lights on the AminusB digit whenever the
//                  snapshotted difference is negative. Otherwise dp is tied
//                  off (never lit).

module seg_display_mux #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] AplusB,
    input  logic [3:0] AminusB,
    input  logic       hold,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] COUNT_MAX = CW'(REFRESH_DIV - 1);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic [3:0] diff;
    } shadow_t;

    logic [CW-1:0] count;
    logic [1:0]    digit_idx;
    logic          load_pending;
    shadow_t       shadow;

    logic          tick;
    logic          load;
    logic [3:0]    digit_val;

    // Hex glyphs for a common-anode display (segment lit when its bit is 0).
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // The counter sits at 0 during the post-reset load cycle, so the first
    // digit gets its full REFRESH_DIV cycles once the blank cycle is over.
    assign tick = !load_pending && (count == COUNT_MAX);

    // Frame boundary coincides with the idx 3->0 wrap; the very first load
    // after reset ignores hold so the display never shows stale zeros.
    assign load = load_pending || (tick && (digit_idx == 2'd3) && !hold);

    always_comb begin
        // NOTE: a default before the case keeps this purely combinational;
        // an unassigned path would infer a latch.
        digit_val = shadow.diff;
        case (digit_idx)
            2'd0: digit_val = shadow.diff;
            2'd1: digit_val = shadow.sum;
            2'd2: digit_val = shadow.b;
            2'd3: digit_val = shadow.a;
            default: digit_val = shadow.diff;
        endcase
    end

    // Scan timing: refresh counter, digit index, and the first-load flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            count        <= '0;
            digit_idx    <= 2'd0;
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (!load_pending) begin
                count <= tick ? '0 : count + 1'b1;
            end
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
        end
    end

    // Shadow snapshot and frame strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow is only 16 flops, so it is cleared on reset like
            // any other register; it is not an array that needs a reset-free RAM.
            shadow <= '0;
            frame  <= 1'b0;
        end else begin
            frame <= load;
            if (load) begin
                shadow <= '{a: A, b: B, sum: AplusB, diff: AminusB};
            end
        end
    end

    // Registered display outputs, one clock behind digit_idx. They stay blank
    // on the load cycle right after reset, before the shadow holds real data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else if (load_pending) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= hex7(digit_val);
        end
    end

`ifdef SEG_DP_NEG_EN
    // Point marks a negative difference, shown only on the AminusB digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp <= 1'b1;
        end else if (load_pending) begin
            dp <= 1'b1;
        end else begin
            dp <= (digit_idx == 2'd0) ? ~shadow.diff[3] : 1'b1;
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux
//   Self-checking bench for seg_display_mux with REFRESH_DIV = 4. Expected
//   digit contents are pushed to a queue when the inputs that will be
//   snapshotted are driven, and popped as each digit comes up on the display.

module tb_seg_display_mux;

    localparam int RD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] A, B, AplusB, AminusB;
    logic       hold;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    int asserts;
    int failures;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    // What the shadow should hold after the most recent load.
    logic [3:0] sh_a, sh_b, sh_s, sh_d;

    seg_display_mux #(.REFRESH_DIV(RD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .AplusB  (AplusB),
        .AminusB (AminusB),
        .hold    (hold),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .frame   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic dp_exp(input logic [3:0] d);
`ifdef SEG_DP_NEG_EN
        dp_exp = ~d[3];
`else
        dp_exp = 1'b1 | d[0];
`endif
    endfunction

    // Queue one frame worth of digits for the current shadow model.
    task automatic push_frame();
        exp_q.push_back('{an: 4'b1110, seg: glyph(sh_d), dp: dp_exp(sh_d)});
        exp_q.push_back('{an: 4'b1101, seg: glyph(sh_s), dp: 1'b1});
        exp_q.push_back('{an: 4'b1011, seg: glyph(sh_b), dp: 1'b1});
        exp_q.push_back('{an: 4'b0111, seg: glyph(sh_a), dp: 1'b1});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] a, b, s, d, input logic h);
        A = a; B = b; AplusB = s; AminusB = d; hold = h;
    endtask

    // Called right after a frame pulse: drives new inputs, scans one frame
    // against the queue, and checks whether the closing boundary loads.
    task automatic do_frame(input logic [3:0] a, b, s, d, input logic h, input string tag);
        exp_t e;
        drive(a, b, s, d, h);
        for (int dg = 0; dg < 4; dg++) begin
            if (exp_q.size() == 0) begin
                asserts++; failures++;
                $display("FAIL %s scoreboard empty at digit %0d", tag, dg);
                e = '{an: 4'b1111, seg: 7'h7f, dp: 1'b1};
            end else begin
                e = exp_q.pop_front();
            end
            for (int k = 0; k < RD; k++) begin
                step();
                asserts++;
                if ({an, seg, dp} !== e) begin
                    failures++;
                    $display("FAIL %s digit%0d cyc%0d: got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                             tag, dg, k, an, seg, dp, e.an, e.seg, e.dp);
                end
                asserts++;
                if (frame !== ((dg == 3 && k == RD - 1) ? !h : 1'b0)) begin
                    failures++;
                    $display("FAIL %s frame digit%0d cyc%0d: got %b exp %b",
                             tag, dg, k, frame, (dg == 3 && k == RD - 1) ? !h : 1'b0);
                end
            end
        end
        if (!h) begin
            sh_a = a; sh_b = b; sh_s = s; sh_d = d;
        end
        push_frame();
    endtask

    // Release reset with the current inputs and check the first-clock load.
    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        sh_a = A; sh_b = B; sh_s = AplusB; sh_d = AminusB;
        push_frame();
        step();
        asserts++;
        if (frame !== 1'b1) begin
            failures++;
            $display("FAIL %s first-load frame: got %b exp 1", tag, frame);
        end
        asserts++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            failures++;
            $display("FAIL %s blank on load clock: got an=%b seg=%b dp=%b exp 1111/1111111/1",
                     tag, an, seg, dp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'd3, 4'd5, 4'd8, 4'hE, 1'b1);  // hold must not block the first load
        repeat (3) step();
        asserts++;
        if ({an, seg, dp, frame} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got an=%b seg=%b dp=%b frame=%b exp 1111/1111111/1/0",
                     an, seg, dp, frame);
        end
        release_reset("reset_release");
    endtask

    // First frame shows 3,5,8,E; A changes to 9 inside it and appears next frame.
    task automatic test_mid_frame();
        do_frame(4'd9, 4'd5, 4'd8, 4'hE, 1'b0, "mid_frame_old");
        do_frame(4'd9, 4'd5, 4'd8, 4'hE, 1'b0, "mid_frame_new");
    endtask

    task automatic test_hold();
        do_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, "hold_1");
        do_frame(4'd7, 4'd6, 4'hD, 4'h1, 1'b1, "hold_2");
        do_frame(4'd7, 4'd6, 4'hD, 4'h1, 1'b0, "hold_release");
        do_frame(4'd7, 4'd6, 4'hD, 4'h1, 1'b0, "hold_loaded");
    endtask

    task automatic test_dp();
        do_frame(4'd2, 4'd6, 4'd8, 4'hC, 1'b0, "dp_load");
        do_frame(4'd2, 4'd6, 4'd8, 4'h4, 1'b0, "dp_negative");
        do_frame(4'd2, 4'd6, 4'd8, 4'h4, 1'b0, "dp_positive");
    endtask

    task automatic test_async_reset();
        repeat (2 * RD + 1) step();
        asserts++;
        if (an !== 4'b1011) begin
            failures++;
            $display("FAIL async_pre an: got %b exp 1011", an);
        end
        #2 rst_n = 1'b0;
        #1;
        asserts++;
        if ({an, seg, dp, frame} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL async_blank: got an=%b seg=%b dp=%b frame=%b exp 1111/1111111/1/0",
                     an, seg, dp, frame);
        end
        exp_q.delete();
        drive(4'hA, 4'h3, 4'hD, 4'h7, 1'b0);
        step();
        release_reset("async_release");
        do_frame(4'hA, 4'h3, 4'hD, 4'h7, 1'b0, "async_restart");
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            do_frame(4'd5, 4'd0, 4'd5, 4'(i), 1'b0, $sformatf("sweep_%0d", i));
        end
        do_frame(4'd5, 4'd0, 4'd5, 4'd0, 1'b0, "sweep_last");
    endtask

    initial begin
        asserts  = 0;
        failures = 0;
        test_reset();
        test_mid_frame();
        test_hold();
        test_dp();
        test_async_reset();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
